// File: rtl/cpu_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_responder
//  Description : Target side of the CPU bus. Captures a request from the
//                address/data/valid handshake and decodes it to internal RAM
//                ($0000-$1FFF, 2 KiB mirrored x4), PRG ROM ($8000-$FFFF) or
//                unmapped space. It then services the request through a
//                synchronous RAM port or a variable-latency ROM port, and
//                presents the result with a held valid flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clock_i           in   1   single clock, rising edge
//   reset_i           in   1   synchronous, active-low reset
//   address_i         in  16   CPU address
//   address_valid_i   in   1   CPU address valid (level)
//   data_i            in   8   CPU write data
//   data_valid_i      in   1   write strobe (write when high with address valid)
//   data_o            out  8   read data / open-bus value
//   data_valid_o      out  1   response valid, held until the request changes
//   ram_address_o     out 11   RAM word address
//   ram_data_o        out  8   RAM write data
//   ram_write_o       out  1   RAM write enable, one-cycle pulse
//   ram_data_i        in   8   RAM read data, RAM_LATENCY after address
//   rom_address_o     out 15   ROM address
//   rom_read_o        out  1   ROM read request, one-cycle pulse
//   rom_data_i        in   8   ROM read data
//   rom_data_valid_i  in   1   ROM data qualifier, one-cycle pulse
// ============================================================================
module cpu_bus_responder #(
   parameter int ROM_TIMEOUT = 8,  // cycles to wait for ROM data (>=2)
   parameter int RAM_LATENCY = 1   // RAM read latency in cycles (1..3)
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic [15:0] address_i,
   input  logic        address_valid_i,
   input  logic [7:0]  data_i,
   input  logic        data_valid_i,
   output logic [7:0]  data_o,
   output logic        data_valid_o,
   output logic [10:0] ram_address_o,
   output logic [7:0]  ram_data_o,
   output logic        ram_write_o,
   input  logic [7:0]  ram_data_i,
   output logic [14:0] rom_address_o,
   output logic        rom_read_o,
   input  logic [7:0]  rom_data_i,
   input  logic        rom_data_valid_i
);

   // The wait counter only ever needs to reach ROM_TIMEOUT; RAM_LATENCY is
   // at most 3 and ROM_TIMEOUT at least 2, so this width covers both.
   localparam int               CNT_W      = $clog2(ROM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] c_ROM_LAST = CNT_W'(ROM_TIMEOUT);
   localparam logic [CNT_W-1:0] c_RAM_LAST = CNT_W'(RAM_LATENCY - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DECODE   = 3'd1,
      S_RAM_WAIT = 3'd2,
      S_ROM_WAIT = 3'd3,
      S_HOLD     = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [15:0]      r_addr;
   logic [7:0]       r_wdata;
   logic             r_write;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_data;
   logic [7:0]       r_open_bus;
   logic             r_valid;
   logic             r_ram_write;
   logic             r_rom_read;

   logic             w_capture;
   logic             w_load_data;
   logic [7:0]       w_data_next;
   logic             w_cnt_clr;
   logic             w_cnt_inc;
   logic             w_valid_next;
   logic             w_ram_write;
   logic             w_rom_read;
   logic             w_is_ram;
   logic             w_is_rom;

   // $0000-$1FFF is RAM (bits 12:11 ignored -> mirroring), $8000-$FFFF ROM.
   assign w_is_ram = (r_addr[15:13] == 3'b000);
   assign w_is_rom = r_addr[15];

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_load_data  = 1'b0;
      w_data_next  = r_data;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_valid_next = 1'b0;
      w_ram_write  = 1'b0;
      w_rom_read   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (address_valid_i) begin
               w_capture    = 1'b1;
               w_next_state = S_DECODE;
            end
         end

         S_DECODE: begin
            w_cnt_clr = 1'b1;
            if (w_is_ram) begin
               if (r_write) begin
                  w_ram_write  = 1'b1;
                  w_load_data  = 1'b1;
                  w_data_next  = r_wdata;
                  w_next_state = S_HOLD;
               end else begin
                  w_next_state = S_RAM_WAIT;
               end
            end else if (w_is_rom && !r_write) begin
               w_rom_read   = 1'b1;
               w_next_state = S_ROM_WAIT;
            end else begin
               // ROM write or unmapped: no port activity. A write still
               // drives its own byte onto the bus; a read sees open bus.
               w_load_data  = 1'b1;
               w_data_next  = r_write ? r_wdata : r_open_bus;
               w_next_state = S_HOLD;
            end
         end

         S_RAM_WAIT: begin
            if (r_cnt == c_RAM_LAST) begin
               w_load_data  = 1'b1;
               w_data_next  = ram_data_i;
               w_next_state = S_HOLD;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end

         S_ROM_WAIT: begin
            // Data arriving on the final allowed cycle wins over timeout.
            if (rom_data_valid_i) begin
               w_load_data  = 1'b1;
               w_data_next  = rom_data_i;
               w_next_state = S_HOLD;
            end else if (r_cnt == c_ROM_LAST) begin
               w_load_data  = 1'b1;
               w_data_next  = r_open_bus;
               w_next_state = S_HOLD;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end

         S_HOLD: begin
            // A different address (or dropped valid) is a new request; the
            // same address held valid is the same request and is not redone.
            if (!address_valid_i || (address_i != r_addr)) begin
               w_next_state = S_IDLE;
            end else begin
               w_valid_next = 1'b1;
            end
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         r_addr      <= 16'h0000;
         r_wdata     <= 8'h00;
         r_write     <= 1'b0;
         r_cnt       <= '0;
         r_data      <= 8'h00;
         r_open_bus  <= 8'h00;
         r_valid     <= 1'b0;
         r_ram_write <= 1'b0;
         r_rom_read  <= 1'b0;
      end else begin
         if (w_capture) begin
            r_addr  <= address_i;
            r_wdata <= data_i;
            r_write <= data_valid_i;
         end
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end
         if (w_load_data) begin
            r_data     <= w_data_next;
            r_open_bus <= w_data_next;
         end
         r_valid     <= w_valid_next;
         r_ram_write <= w_ram_write;
         r_rom_read  <= w_rom_read;
      end
   end

   assign data_o        = r_data;
   assign data_valid_o  = r_valid;
   assign ram_address_o = r_addr[10:0];
   assign ram_data_o    = r_wdata;
   assign ram_write_o   = r_ram_write;
   assign rom_address_o = r_addr[14:0];
   assign rom_read_o    = r_rom_read;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_bus_responder
//  Description : Directed self-checking bench for cpu_bus_responder with a
//                one-cycle synchronous RAM model and a programmable-latency
//                ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_responder;

   localparam int ROM_TIMEOUT = 8;
   localparam int RAM_LATENCY = 1;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic [15:0] address_i;
   logic        address_valid_i;
   logic [7:0]  data_i;
   logic        data_valid_i;
   logic [7:0]  data_o;
   logic        data_valid_o;
   logic [10:0] ram_address_o;
   logic [7:0]  ram_data_o;
   logic        ram_write_o;
   logic [7:0]  ram_data_i;
   logic [14:0] rom_address_o;
   logic        rom_read_o;
   logic [7:0]  rom_data_i;
   logic        rom_data_valid_i;

   int checks   = 0;
   int failures = 0;

   always #5 clock_i = ~clock_i;

   cpu_bus_responder #(
      .ROM_TIMEOUT (ROM_TIMEOUT),
      .RAM_LATENCY (RAM_LATENCY)
   ) u_dut (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .address_i        (address_i),
      .address_valid_i  (address_valid_i),
      .data_i           (data_i),
      .data_valid_i     (data_valid_i),
      .data_o           (data_o),
      .data_valid_o     (data_valid_o),
      .ram_address_o    (ram_address_o),
      .ram_data_o       (ram_data_o),
      .ram_write_o      (ram_write_o),
      .ram_data_i       (ram_data_i),
      .rom_address_o    (rom_address_o),
      .rom_read_o       (rom_read_o),
      .rom_data_i       (rom_data_i),
      .rom_data_valid_i (rom_data_valid_i)
   );

   // Synchronous RAM, one cycle of read latency.
   logic [7:0] mem [0:2047];
   logic [7:0] ram_q;
   always @(posedge clock_i) begin
      if (ram_write_o === 1'b1) mem[ram_address_o] <= ram_data_o;
      ram_q <= mem[ram_address_o];
   end
   assign ram_data_i = ram_q;

   // ROM answers rom_lat cycles after a read pulse; rom_lat==0 never answers.
   int         rom_lat  = 0;
   int         rom_cnt  = 0;
   logic [7:0] rom_byte = 8'h00;
   always @(posedge clock_i) begin
      if (rom_read_o === 1'b1)  rom_cnt <= rom_lat;
      else if (rom_cnt > 0)     rom_cnt <= rom_cnt - 1;
   end
   assign rom_data_valid_i = (rom_cnt == 1);
   assign rom_data_i       = rom_byte;

   // Port pulse counters.
   int n_rom_read  = 0;
   int n_ram_write = 0;
   always @(posedge clock_i) begin
      if (rom_read_o === 1'b1)  n_rom_read  <= n_rom_read + 1;
      if (ram_write_o === 1'b1) n_ram_write <= n_ram_write + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drop_request();
      address_valid_i = 1'b0;
      data_valid_i    = 1'b0;
      tick(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int rn;
      int wn;

      // ---------------- reset with random bus activity ----------------
      reset_i         = 1'b0;
      address_i       = 16'h0000;
      address_valid_i = 1'b0;
      data_i          = 8'h00;
      data_valid_i    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         address_i       = 16'($urandom);
         address_valid_i = 1'($urandom);
         data_i          = 8'($urandom);
         data_valid_i    = 1'($urandom);
         tick(1);
      end
      chk("rst_data",      32'(data_o),        32'h00);
      chk("rst_valid",     32'(data_valid_o),  32'h0);
      chk("rst_ram_write", 32'(ram_write_o),   32'h0);
      chk("rst_rom_read",  32'(rom_read_o),    32'h0);
      chk("rst_ram_addr",  32'(ram_address_o), 32'h000);
      chk("rst_rom_addr",  32'(rom_address_o), 32'h0000);

      reset_i         = 1'b1;
      address_valid_i = 1'b0;
      data_valid_i    = 1'b0;
      rn = n_rom_read;
      wn = n_ram_write;
      tick(3);
      chk("post_rst_rom_pulses", 32'(n_rom_read - rn),  32'd0);
      chk("post_rst_ram_pulses", 32'(n_ram_write - wn), 32'd0);
      chk("post_rst_valid",      32'(data_valid_o),     32'h0);

      // ---------------- ROM read $FFFC, 3-cycle ROM ----------------
      rom_lat = 3; rom_byte = 8'h34;
      address_i = 16'hFFFC; data_valid_i = 1'b0; address_valid_i = 1'b1;
      rn = n_rom_read;
      tick(1);                       // capture edge
      tick(5);
      chk("rom_lat_not_yet",  32'(data_valid_o),  32'h0);
      tick(1);                       // 3 + 3 cycles
      chk("rom_valid",        32'(data_valid_o),  32'h1);
      chk("rom_data",         32'(data_o),        32'h34);
      chk("rom_addr",         32'(rom_address_o), 32'h7FFC);
      tick(3);
      chk("rom_valid_held",   32'(data_valid_o),  32'h1);
      chk("rom_one_pulse",    32'(n_rom_read - rn), 32'd1);

      // ---------------- RAM write $0801 <- A5 ----------------
      drop_request();
      chk("drop_valid_falls", 32'(data_valid_o), 32'h0);
      address_i = 16'h0801; data_i = 8'hA5; data_valid_i = 1'b1; address_valid_i = 1'b1;
      wn = n_ram_write;
      tick(1);
      tick(1);
      chk("wr_pulse",         32'(ram_write_o),   32'h1);
      chk("wr_ram_addr",      32'(ram_address_o), 32'h001);
      chk("wr_ram_data",      32'(ram_data_o),    32'hA5);
      tick(1);
      chk("wr_valid",         32'(data_valid_o),  32'h1);
      chk("wr_data_o",        32'(data_o),        32'hA5);
      tick(3);
      chk("wr_single_write",  32'(n_ram_write - wn), 32'd1);

      // ---------------- RAM read $1801 (mirror of $0801) ----------------
      drop_request();
      address_i = 16'h1801; address_valid_i = 1'b1;
      tick(1);
      tick(2);
      chk("rd_lat_not_yet",   32'(data_valid_o),  32'h0);
      tick(1);                       // 2 + RAM_LATENCY cycles
      chk("rd_valid",         32'(data_valid_o),  32'h1);
      chk("rd_mirror_data",   32'(data_o),        32'hA5);
      chk("rd_ram_addr",      32'(ram_address_o), 32'h001);

      // ---------------- ROM timeout: open bus = A5 ----------------
      drop_request();
      rom_lat = 0;
      address_i = 16'h8000; address_valid_i = 1'b1;
      tick(1);
      tick(10);
      chk("tmo_not_yet",      32'(data_valid_o),  32'h0);
      tick(1);                       // 3 + ROM_TIMEOUT cycles
      chk("tmo_valid",        32'(data_valid_o),  32'h1);
      chk("tmo_open_bus",     32'(data_o),        32'hA5);

      // ---------------- ROM read of 5A, then unmapped $4000 ----------------
      drop_request();
      rom_lat = 1; rom_byte = 8'h5A;
      address_i = 16'hC000; address_valid_i = 1'b1;
      tick(1);
      tick(4);
      chk("rom5a_valid",      32'(data_valid_o),  32'h1);
      chk("rom5a_data",       32'(data_o),        32'h5A);
      drop_request();
      rn = n_rom_read;
      wn = n_ram_write;
      address_i = 16'h4000; address_valid_i = 1'b1;
      tick(1);
      tick(1);
      chk("unm_not_yet",      32'(data_valid_o),  32'h0);
      tick(1);
      chk("unm_valid",        32'(data_valid_o),  32'h1);
      chk("unm_data",         32'(data_o),        32'h5A);
      tick(2);
      chk("unm_no_rom",       32'(n_rom_read - rn),  32'd0);
      chk("unm_no_ram",       32'(n_ram_write - wn), 32'd0);

      // ---------------- ROM-region write: no port activity ----------------
      drop_request();
      address_i = 16'h9000; data_i = 8'h3C; data_valid_i = 1'b1; address_valid_i = 1'b1;
      tick(1);
      tick(2);
      chk("romwr_valid",      32'(data_valid_o),  32'h1);
      chk("romwr_data",       32'(data_o),        32'h3C);
      chk("romwr_no_rom",     32'(n_rom_read - rn),  32'd0);
      chk("romwr_no_ram",     32'(n_ram_write - wn), 32'd0);

      // ---------------- address change in HOLD, then reset mid-ROM_WAIT ----------------
      drop_request();
      rom_lat = 2; rom_byte = 8'h34;
      address_i = 16'hFFFC; address_valid_i = 1'b1;
      tick(1);
      tick(5);
      chk("chg_first_valid",  32'(data_valid_o),  32'h1);
      chk("chg_first_data",   32'(data_o),        32'h34);
      address_i = 16'hFFFD; rom_byte = 8'h99;
      rn = n_rom_read;
      tick(1);
      chk("chg_valid_falls",  32'(data_valid_o),  32'h0);
      tick(1);                       // new request captured
      tick(1);
      chk("chg_new_rom_read", 32'(rom_read_o),    32'h1);
      chk("chg_new_rom_addr", 32'(rom_address_o), 32'h7FFD);
      tick(1);                       // now waiting on ROM
      reset_i = 1'b0; address_valid_i = 1'b0;
      tick(1);
      chk("abort_valid",      32'(data_valid_o),  32'h0);
      chk("abort_data",       32'(data_o),        32'h00);
      chk("abort_rom_read",   32'(rom_read_o),    32'h0);
      tick(1);
      reset_i = 1'b1;
      tick(2);
      chk("late_rom_ignored_valid", 32'(data_valid_o), 32'h0);
      chk("late_rom_ignored_data",  32'(data_o),       32'h00);
      chk("chg_one_rom_read", 32'(n_rom_read - rn), 32'd1);

      // Open-bus latch was cleared by reset.
      address_i = 16'h4000; address_valid_i = 1'b1;
      tick(1);
      tick(2);
      chk("post_abort_valid", 32'(data_valid_o),  32'h1);
      chk("post_abort_data",  32'(data_o),        32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
